contador_programa: RTL and testbench
====================================

# contador_programa

Parametrised program counter with a built-in return-address stack, the successor to the plain parallel-load PC register in the nibble processor datapath. It holds, loads, or increments the PC. It also supports call and return through a small LIFO, with full/empty status and sticky error flags. It sits between the control unit (which drives the command strobes) and the instruction memory address bus.

## Interface
- WIDTH, 8, PC and return-address width in bits
- DEPTH, 4, return-stack entries (≥1)
- STEP, 1, increment amount applied by inc and to the pushed return address
- RESET_VAL, 0, PC value after reset
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  global enable; when 0 all state holds and commands are ignored
- load  input  1  PC <= data_in
- call  input  1  push PC+STEP, PC <= data_in
- ret  input  1  PC <= popped address
- inc  input  1  PC <= PC+STEP
- data_in  input  WIDTH  load/call target
- data_out  output  WIDTH  current PC, registered
- sp_count  output  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- stack_empty  output  1  sp_count==0
- stack_full  output  1  sp_count==DEPTH
- overflow  output  1  sticky: call attempted while full
- underflow  output  1  sticky: ret attempted while empty

## Operation
- Reset (rst=1 at edge, overrides en and all commands): data_out=RESET_VAL, sp_count=0, stack_empty=1, stack_full=0, overflow=0, underflow=0. Stack contents are don't-care.
- With en=1, one command executes per edge. Fixed priority: load > call > ret > inc > hold. Lower-priority strobes asserted on the same edge are discarded.
- load: PC <= data_in. Stack untouched.
- call, not full: stack[sp] <= PC+STEP (mod 2^WIDTH), sp_count+1, PC <= data_in.
- call, full: no push, PC unchanged, overflow <= 1.
- ret, not empty: PC <= top entry, sp_count−1.
- ret, empty: PC unchanged, underflow <= 1.
- inc: PC <= PC+STEP, modulo 2^WIDTH. Wraps silently with no flag.
- hold: no strobe asserted, or en=0. Everything keeps its value, including the flags.
- overflow and underflow clear only on rst.
- All arithmetic is WIDTH bits, unsigned, with the carry discarded.

## Timing
- All outputs are registered. A command sampled at edge N is visible on data_out/sp_count after edge N. Latency is 1 cycle and there is no combinational path from inputs to outputs.
- stack_empty and stack_full are decoded from the registered sp_count, so they are consistent with it in the same cycle.
- Back-to-back commands are legal every cycle. Example: call at N, then ret at N+1 returns to the pushed address after N+1.
- Reset mid-sequence (e.g. during a chain of calls) takes effect on that edge. The next non-reset command starts from the empty stack.
- en=0 on an edge where rst=0 means a full freeze. Strobes are not latched for later use.

## Structure
- Shared package pc_pkg: the command priority encoding as localparams (CMD_HOLD, CMD_INC, CMD_RET, CMD_CALL, CMD_LOAD), plus a function for the sp_count width.
- Sub-module pilha_lifo (WIDTH, DEPTH), instantiated once:
  - Ports: push, pop, push data, top data, count, full, empty.
  - Ignores push when full and pop when empty.
- The top level holds the PC register, the priority encoder and the flag registers.

## Test plan
WIDTH=8, DEPTH=4, STEP=1.
- Reset: rst=1 for one edge → data_out=8'h00, sp_count=0, stack_empty=1, overflow=0, underflow=0.
- Enable and increment:
  - en=0, inc=1 for 2 edges → data_out stays 8'h00.
  - en=1, inc=1 for 3 edges → 8'h03.
  - Load 8'hFF, then inc → 8'h00 (wrap).
- Call/return: load 8'h40, then call with data_in=8'h80 → data_out=8'h80, sp_count=1. Then ret → data_out=8'h41, stack_empty=1.
- Overflow: 4 calls fill the stack (stack_full=1), then a 5th call with 8'hAA → data_out unchanged, sp_count=4, overflow=1. overflow stays 1 through later commands, and rst clears it.
- Underflow: ret on an empty stack with data_out=8'h12 → data_out stays 8'h12, underflow=1, sp_count=0.
- Priority:
  - load=1 and inc=1 with data_in=8'h30 → 8'h30.
  - call=1 and ret=1 with data_in=8'h50 from PC 8'h30 → PC 8'h50, sp_count+1, pushed value 8'h31.
  - rst=1 together with load=1 → reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Command encoding and sizing helper shared by the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam logic [2:0] CMD_HOLD = 3'd0;
    localparam logic [2:0] CMD_INC  = 3'd1;
    localparam logic [2:0] CMD_RET  = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_LOAD = 3'd4;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pilha_lifo.sv
// ============================================================================
// Module      : pilha_lifo
// Description : Return-address LIFO; push ignored when full, pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pilha_lifo
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                push_data,
    output logic [WIDTH-1:0]                top_data,
    output logic [sp_width(DEPTH)-1:0]      count,
    output logic                            full,
    output logic                            empty
);

    localparam int CW = sp_width(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic [CW-1:0]    w_rd_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_rd_cnt  = r_count - CW'(1);
    assign w_wr_idx  = AW'(r_count);
    assign w_rd_idx  = AW'(w_rd_cnt);
    // Read index is meaningless when empty; callers never consume it then.
    assign top_data  = r_mem[w_rd_idx];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= w_rd_cnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/contador_programa.sv
// ============================================================================
// Module      : contador_programa
// Description : Program counter with load/inc and call/return via a LIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_programa
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         load,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         inc,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   sp_count,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         overflow,
    output logic                         underflow
);

    logic [WIDTH-1:0] r_pc;
    logic             r_overflow;
    logic             r_underflow;
    logic [2:0]       w_cmd;
    logic [WIDTH-1:0] w_pc_step;
    logic [WIDTH-1:0] w_top;
    logic             w_push;
    logic             w_pop;

    assign w_pc_step = r_pc + STEP;

    // en low collapses every strobe to hold, so nothing is latched for later.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (en) begin
            if (load)      w_cmd = CMD_LOAD;
            else if (call) w_cmd = CMD_CALL;
            else if (ret)  w_cmd = CMD_RET;
            else if (inc)  w_cmd = CMD_INC;
        end
    end

    assign w_push = (w_cmd == CMD_CALL) && !stack_full;
    assign w_pop  = (w_cmd == CMD_RET)  && !stack_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VAL;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_cmd)
                CMD_LOAD: r_pc <= data_in;
                CMD_CALL: begin
                    if (stack_full) r_overflow <= 1'b1;
                    else            r_pc       <= data_in;
                end
                CMD_RET: begin
                    if (stack_empty) r_underflow <= 1'b1;
                    else             r_pc        <= w_top;
                end
                CMD_INC:  r_pc <= w_pc_step;
                default:  r_pc <= r_pc;
            endcase
        end
    end

    pilha_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_pilha (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_step),
        .top_data  (w_top),
        .count     (sp_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign data_out  = r_pc;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_contador_programa.sv
// ============================================================================
// Module      : tb_contador_programa
// Description : Directed vector bench for contador_programa (8-bit, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_contador_programa;

    logic       clk = 1'b0;
    logic       rst, en, load, call, ret, inc;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [2:0] sp_count;
    logic       stack_empty, stack_full, overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst, en, load, call, ret, inc;
        logic [7:0] din;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ov, un;
    } vec_t;

    vec_t vecs[$];

    contador_programa #(
        .WIDTH     (8),
        .DEPTH     (4),
        .STEP      (8'd1),
        .RESET_VAL (8'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .inc         (inc),
        .data_in     (data_in),
        .data_out    (data_out),
        .sp_count    (sp_count),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, e, l, c, rt, i, input logic [7:0] d,
                       input logic [7:0] p, input logic [2:0] s, input logic o, u);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.call = c; v.ret = rt; v.inc = i;
        v.din = d; v.pc = p; v.sp = s; v.ov = o; v.un = u;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, clock it in, then sample 1 time unit later.
    task automatic step(input logic r, e, l, c, rt, i, input logic [7:0] d);
        @(negedge clk);
        rst = r; en = e; load = l; call = c; ret = rt; inc = i; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] p, input logic [2:0] s,
                             input logic o, input logic u);
        check({tag, " pc"}, data_out, p);
        check({tag, " sp"}, {5'd0, sp_count}, {5'd0, s});
        check({tag, " empty"}, {7'd0, stack_empty}, {7'd0, s == 3'd0});
        check({tag, " full"}, {7'd0, stack_full}, {7'd0, s == 3'd4});
        check({tag, " ovf"}, {7'd0, overflow}, {7'd0, o});
        check({tag, " udf"}, {7'd0, underflow}, {7'd0, u});
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0;
        data_in = 8'h00;

        //   rst en ld cl rt in  din     pc     sp  ov un
        add(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h00, 8'h02, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h00, 8'h03, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'h40, 8'h40, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 8'h00, 8'h41, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'h10, 8'h10, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'h20, 8'h20, 2, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'h30, 8'h30, 3, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'h40, 8'h40, 4, 0, 0);
        add(0, 1, 0, 1, 0, 0, 8'hAA, 8'h40, 4, 1, 0);
        add(0, 1, 0, 0, 0, 1, 8'h00, 8'h41, 4, 1, 0);
        add(0, 1, 0, 0, 1, 0, 8'h00, 8'h31, 3, 1, 0);
        add(0, 0, 0, 0, 1, 0, 8'h00, 8'h31, 3, 1, 0);
        add(0, 1, 0, 0, 1, 0, 8'h00, 8'h21, 2, 1, 0);
        add(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 8'h12, 8'h12, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 8'h00, 8'h12, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 8'h30, 8'h30, 0, 0, 1);
        add(0, 1, 0, 1, 1, 0, 8'h50, 8'h50, 1, 0, 1);
        add(0, 1, 0, 0, 1, 0, 8'h00, 8'h31, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 8'h77, 8'h00, 0, 0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].load, vecs[k].call,
                 vecs[k].ret, vecs[k].inc, vecs[k].din);
            check_all($sformatf("vec%0d", k), vecs[k].pc, vecs[k].sp, vecs[k].ov, vecs[k].un);
        end

        // Reset in the middle of a call chain; next ret sees an empty stack.
        step(0, 1, 0, 1, 0, 0, 8'h60);
        check_all("chain1", 8'h60, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0, 8'h70);
        check_all("chain2", 8'h70, 2, 0, 0);
        step(1, 1, 0, 1, 0, 0, 8'h90);
        check_all("chain_rst", 8'h00, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        check_all("chain_ret", 8'h00, 0, 0, 1);

        // Back-to-back call then ret returns to the pushed address.
        step(0, 1, 1, 0, 0, 0, 8'h05);
        check_all("b2b_load", 8'h05, 0, 0, 1);
        step(0, 1, 0, 1, 0, 0, 8'h90);
        check_all("b2b_call", 8'h90, 1, 0, 1);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        check_all("b2b_ret", 8'h06, 0, 0, 1);

        // Strobes held with en low are not remembered once en returns.
        step(0, 0, 1, 0, 0, 0, 8'hEE);
        check_all("frz", 8'h06, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 8'h00);
        check_all("frz_rel", 8'h06, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
